// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG byte conditioner.
package trng_pkg;

  localparam int unsigned TRNG_ADDR_W = 4;
  localparam int unsigned TRNG_DATA_W = 8;

  // Peripheral register addresses
  localparam logic [TRNG_ADDR_W-1:0] TRNG_ADDR_DATA   = 4'd0;
  localparam logic [TRNG_ADDR_W-1:0] TRNG_ADDR_STATUS = 4'd1;
  localparam logic [TRNG_ADDR_W-1:0] TRNG_ADDR_CTRL   = 4'd2;

  // CTRL register bit positions
  localparam int unsigned TRNG_CTRL_ENABLE_BIT = 0;
  localparam int unsigned TRNG_CTRL_CLEAR_BIT  = 1;

  // STATUS register bit positions
  localparam int unsigned TRNG_STAT_RCT_FAIL_BIT = 7;
  localparam int unsigned TRNG_STAT_OVERFLOW_BIT = 6;
  localparam int unsigned TRNG_STAT_ENABLE_BIT   = 5;

  // STATUS register layout as seen by software
  typedef struct packed {
    logic       rct_fail;
    logic       overflow;
    logic       enable;
    logic       rsvd;
    logic [3:0] count;
  } trng_status_t;

  // Von Neumann pair tracking
  typedef enum logic {
    VN_IDLE       = 1'b0,
    VN_HAVE_FIRST = 1'b1
  } vn_state_e;

endpackage

// File: rtl/trng_byte_fifo.sv
// Small synchronous byte FIFO; flush empties it, a pop frees a slot for a same-cycle push.
module trng_byte_fifo
  import trng_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [TRNG_DATA_W-1:0] i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic                   o_full_c,
  output logic                   o_empty_c,
  output logic [CNT_W-1:0]       o_count,
  output logic [TRNG_DATA_W-1:0] o_head_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [TRNG_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_rd_ptr;
  logic [AW-1:0]          r_wr_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_do_pop;
  logic                   w_do_push;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_c  = r_mem[r_rd_ptr];

  // Pop is evaluated first so a full FIFO can accept a push in the same cycle
  assign w_do_pop  = i_pop && !o_empty_c;
  assign w_do_push = i_push && (!o_full_c || w_do_pop);

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && !rst) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/trng_byte_conditioner.sv
// TRNG raw-bit conditioner: repetition-count health test, optional von Neumann
// debiasing, byte packing and a small FIFO exposed as peripheral registers.
// Build option: define TRNG_VON_NEUMANN_EN to insert the von Neumann debiaser.
module trng_byte_conditioner
  import trng_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RCT_CUTOFF = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   raw_bit,
  input  logic                   raw_valid,
  input  logic [TRNG_ADDR_W-1:0] address,
  input  logic                   data_write,
  input  logic [TRNG_DATA_W-1:0] data_in,
  input  logic                   data_read,
  output logic [TRNG_DATA_W-1:0] data_out,
  output logic                   byte_avail
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RCT_W   = 8;
  localparam int unsigned PCNT_W  = 3;

  logic                   r_enable;
  logic                   r_rct_fail;
  logic                   r_overflow;
  logic                   r_rct_prev;
  logic [RCT_W-1:0]       r_rct_cnt;
  logic [TRNG_DATA_W-1:0] r_shift;
  logic [PCNT_W-1:0]      r_pcnt;

  logic                   w_ctrl_wr;
  logic                   w_clear;
  logic                   w_flush;
  logic                   w_raw_take;
  logic                   w_accept;
  logic                   w_accept_bit;
  logic [TRNG_DATA_W-1:0] w_shift_next;
  logic                   w_byte_done;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [CNT_W-1:0]       w_count;
  logic [TRNG_DATA_W-1:0] w_head;
  trng_status_t           w_status;
  logic                   w_unused_ctrl_bits;

  assign w_ctrl_wr  = data_write && (address == TRNG_ADDR_CTRL);
  assign w_clear    = w_ctrl_wr && data_in[TRNG_CTRL_CLEAR_BIT];
  assign w_flush    = w_clear || r_rct_fail;
  assign w_raw_take = raw_valid && r_enable && !r_rct_fail && !w_clear;
  assign w_pop      = data_read && (address == TRNG_ADDR_DATA);
  assign w_unused_ctrl_bits = ^data_in[TRNG_DATA_W-1:2];

  // Enable, sticky health-test failure and sticky overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable   <= 1'b0;
      r_rct_fail <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_enable <= data_in[TRNG_CTRL_ENABLE_BIT];
      if (w_clear) begin
        r_rct_fail <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (r_rct_cnt == RCT_W'(RCT_CUTOFF)) r_rct_fail <= 1'b1;
        if (w_drop)                          r_overflow <= 1'b1;
      end
    end
  end

  // Repetition-count test on the raw stream; a zero count means no previous bit
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_rct_cnt  <= '0;
      r_rct_prev <= 1'b0;
    end else if (w_raw_take) begin
      r_rct_prev <= raw_bit;
      if ((r_rct_cnt == '0) || (raw_bit != r_rct_prev)) begin
        r_rct_cnt <= RCT_W'(1);
      end else if (r_rct_cnt != RCT_W'(RCT_CUTOFF)) begin
        r_rct_cnt <= r_rct_cnt + RCT_W'(1);
      end
    end
  end

`ifdef TRNG_VON_NEUMANN_EN
  vn_state_e r_vn_state;
  vn_state_e w_vn_next;
  logic      r_vn_first;

  // Debias state register; pair state is dropped on clear or health failure
  always_ff @(posedge clk) begin
    if (rst || w_clear || r_rct_fail) begin
      r_vn_state <= VN_IDLE;
      r_vn_first <= 1'b0;
    end else begin
      r_vn_state <= w_vn_next;
      if (w_raw_take && (r_vn_state == VN_IDLE)) r_vn_first <= raw_bit;
    end
  end

  // Debias next state: accept the first bit of an unequal pair
  always_comb begin
    w_vn_next    = r_vn_state;
    w_accept     = 1'b0;
    w_accept_bit = r_vn_first;
    if (w_raw_take) begin
      if (r_vn_state == VN_IDLE) begin
        w_vn_next = VN_HAVE_FIRST;
      end else begin
        w_vn_next = VN_IDLE;
        w_accept  = (raw_bit != r_vn_first);
      end
    end
  end
`else
  assign w_accept     = w_raw_take;
  assign w_accept_bit = raw_bit;
`endif

  assign w_shift_next = {w_accept_bit, r_shift[TRNG_DATA_W-1:1]};
  assign w_byte_done  = w_accept && (r_pcnt == PCNT_W'(7));
  assign w_drop       = w_byte_done && w_full && !w_pop;

  // Byte packer: new bits enter at the MSB; the counter wraps to 0 after a byte
  always_ff @(posedge clk) begin
    if (rst || w_clear || r_rct_fail) begin
      r_shift <= '0;
      r_pcnt  <= '0;
    end else if (w_accept) begin
      r_shift <= w_shift_next;
      r_pcnt  <= r_pcnt + PCNT_W'(1);
    end
  end

  trng_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_byte_done),
    .i_data    (w_shift_next),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count),
    .o_head_c  (w_head)
  );

  assign byte_avail = !w_empty;

  // Register read mux over registered state
  always_comb begin
    w_status          = '0;
    w_status.rct_fail = r_rct_fail;
    w_status.overflow = r_overflow;
    w_status.enable   = r_enable;
    w_status.count    = 4'(w_count);
    data_out          = '0;
    if (address == TRNG_ADDR_DATA) begin
      data_out = w_empty ? '0 : w_head;
    end else if (address == TRNG_ADDR_STATUS) begin
      data_out = w_status;
    end
  end

endmodule

// File: tb/tb_trng_byte_conditioner.sv
// Directed bench for trng_byte_conditioner with a byte scoreboard model.
// Honors TRNG_VON_NEUMANN_EN to match the DUT build.
module tb_trng_byte_conditioner;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CUTOFF = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_bit;
  logic       raw_valid;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic       data_read;
  logic [7:0] data_out;
  logic       byte_avail;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_sr;
  int         m_pc;
  logic       m_vn_have;
  logic       m_vn_first;
  logic       m_en;
  logic       m_ovf;
  logic       m_rct;

  trng_byte_conditioner #(
    .FIFO_DEPTH (DEPTH),
    .RCT_CUTOFF (CUTOFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_bit    (raw_bit),
    .raw_valid  (raw_valid),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_read  (data_read),
    .data_out   (data_out),
    .byte_avail (byte_avail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {m_rct, m_ovf, m_en, 1'b0, 4'(m_q.size())};
  endfunction

  task automatic model_reset_pack();
    m_sr      = 8'h00;
    m_pc      = 0;
    m_vn_have = 1'b0;
  endtask

  task automatic model_accept(input logic b);
    m_sr = {b, m_sr[7:1]};
    m_pc++;
    if (m_pc == 8) begin
      m_pc = 0;
      if (m_q.size() < DEPTH) m_q.push_back(m_sr);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_raw(input logic b);
    if (m_en && !m_rct) begin
`ifdef TRNG_VON_NEUMANN_EN
      if (!m_vn_have) begin
        m_vn_have  = 1'b1;
        m_vn_first = b;
      end else begin
        m_vn_have = 1'b0;
        if (b != m_vn_first) model_accept(m_vn_first);
      end
`else
      model_accept(b);
`endif
    end
  endtask

  task automatic send_raw(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    @(posedge clk); #1;
    raw_valid = 1'b0;
    model_raw(b);
  endtask

  // Sends raw bits that the active build turns into exactly the byte v
  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
`ifdef TRNG_VON_NEUMANN_EN
      send_raw(v[i]);
      send_raw(~v[i]);
`else
      send_raw(v[i]);
`endif
    end
  endtask

  task automatic write_ctrl(input logic [7:0] v);
    address    = 4'd2;
    data_in    = v;
    data_write = 1'b1;
    @(posedge clk); #1;
    data_write = 1'b0;
    m_en = v[0];
    if (v[1]) begin
      m_rct = 1'b0;
      m_ovf = 1'b0;
      m_q.delete();
      model_reset_pack();
    end
  endtask

  task automatic check_status(input string tag);
    address = 4'd1; #1;
    chk(tag, data_out, exp_status());
  endtask

  task automatic check_avail(input string tag);
    chk(tag, 8'(byte_avail), 8'(m_q.size() != 0));
  endtask

  task automatic read_data(input string tag);
    logic [7:0] e;
    e = (m_q.size() > 0) ? m_q[0] : 8'h00;
    address = 4'd0; #1;
    chk(tag, data_out, e);
    data_read = 1'b1;
    @(posedge clk); #1;
    data_read = 1'b0;
    if (m_q.size() > 0) void'(m_q.pop_front());
  endtask

  initial begin
    logic [7:0] pat1 [8];
    logic [7:0] vn_pat [8];
    logic [7:0] fill [5];
    logic       raws [$];
    logic       last;
    logic [7:0] v;

    pat1   = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0};
    vn_pat = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0};
    fill   = '{8'hA5, 8'h3C, 8'h81, 8'h7E, 8'h5A};

    rst = 1'b1; raw_bit = 1'b0; raw_valid = 1'b0; address = 4'd0;
    data_write = 1'b0; data_in = 8'h00; data_read = 1'b0;
    m_en = 1'b0; m_ovf = 1'b0; m_rct = 1'b0; m_vn_first = 1'b0;
    model_reset_pack();

    // Reset state: every address reads zero, nothing available
    repeat (3) @(posedge clk);
    #1;
    chk("reset_avail", 8'(byte_avail), 8'h00);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a); #1;
      chk("reset_dout", data_out, 8'h00);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Raw bits are ignored while disabled
    for (int i = 0; i < 8; i++) send_raw(pat1[i][0]);
    check_avail("disabled_avail");
    check_status("disabled_status");

    write_ctrl(8'h01);
    check_status("enable_status");
    chk("enable_status_const", data_out, 8'h20);

    // First byte from 1,0,1,1,0,0,1,0
    for (int i = 0; i < 8; i++) send_raw(pat1[i][0]);
    check_avail("first_avail");
    check_status("first_status");
`ifndef TRNG_VON_NEUMANN_EN
    address = 4'd0; #1;
    chk("first_byte_const", data_out, 8'h4D);
    chk("first_avail_const", 8'(byte_avail), 8'h01);
`endif
    read_data("first_read");
    check_status("first_after_read");

    // Pairs 10,11,01,00 repeated four times
    write_ctrl(8'h03);
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++) send_raw(vn_pat[i][0]);
    check_status("pairs_status");
`ifdef TRNG_VON_NEUMANN_EN
    address = 4'd0; #1;
    chk("vn_byte_const", data_out, 8'h55);
`endif
    for (int i = 0; i < DEPTH; i++) read_data("pairs_drain");

    // Overflow: fill the FIFO, then complete one more byte
    write_ctrl(8'h03);
    for (int i = 0; i < 5; i++) send_byte(fill[i]);
    check_status("ovf_status");
    chk("ovf_status_const", data_out, 8'h64);
    address = 4'd0; #1;
    chk("ovf_head_const", data_out, 8'hA5);
    read_data("ovf_first_read");
    check_status("ovf_after_read");

    // Full FIFO with a byte completing on the same cycle as a pop
    send_byte(8'hC3);
    check_status("refill_status");
    v = 8'h96;
    raws.delete();
    for (int i = 0; i < 8; i++) begin
`ifdef TRNG_VON_NEUMANN_EN
      raws.push_back(v[i]);
      raws.push_back(~v[i]);
`else
      raws.push_back(v[i]);
`endif
    end
    last = raws.pop_back();
    foreach (raws[i]) send_raw(raws[i]);
    address = 4'd0; #1;
    chk("simul_head", data_out, m_q[0]);
    raw_bit   = last;
    raw_valid = 1'b1;
    data_read = 1'b1;
    @(posedge clk); #1;
    raw_valid = 1'b0;
    data_read = 1'b0;
    void'(m_q.pop_front());
    model_raw(last);
    check_status("simul_status");
    chk("simul_status_const", data_out, 8'h64);
    for (int i = 0; i < DEPTH; i++) read_data("simul_drain");

    // Empty read returns zero and does not disturb the count
    read_data("empty_read");
    check_status("empty_status");
    check_avail("empty_avail");

    // Reset in the middle of a byte discards the partial bits
    send_raw(1'b1); send_raw(1'b1); send_raw(1'b0); send_raw(1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_en = 1'b0; m_ovf = 1'b0; m_rct = 1'b0;
    m_q.delete();
    model_reset_pack();
    check_status("midrst_status");
    write_ctrl(8'h01);
    send_byte(8'h3A);
    address = 4'd0; #1;
    chk("midrst_byte_const", data_out, 8'h3A);
    read_data("midrst_read");

    // Repetition-count failure on a constant stream, then recovery
    write_ctrl(8'h03);
    for (int i = 0; i < CUTOFF; i++) send_raw(1'b1);
    repeat (3) @(posedge clk);
    #1;
    m_rct = 1'b1;
    m_q.delete();
    model_reset_pack();
    check_status("rct_status");
    chk("rct_status_const", data_out, 8'hA0);
    check_avail("rct_avail");
    send_byte(8'h5A);
    check_avail("rct_blocked_avail");
    write_ctrl(8'h03);
    check_status("rct_cleared_status");
    chk("rct_cleared_const", data_out, 8'h20);
    send_byte(8'hC6);
    check_avail("rct_recover_avail");
    read_data("rct_recover_read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
